// File: rtl/priority_pkg.sv
// Shared definitions for the priority encoder/decoder pair.
// Holds the index width, the derived line count, the decoder FSM state
// encodings, the request payload layout and the index-to-one-hot helper.
package priority_pkg;

  // Index width and number of request lines shared by encoder and decoder.
  localparam int unsigned N_SEL = 3;
  localparam int unsigned N_OUT = 1 << N_SEL;

  // Default width of the hold-length input and the hold counter.
  localparam int unsigned HOLD_W_DEF = 4;

  // Decoder FSM state encodings.
  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_DRIVE = 2'd1;
  localparam logic [ST_W-1:0] ST_GAP   = 2'd2;

  // Request payload as presented on the decoder's input side.
  typedef struct packed {
    logic                  zero;
    logic [N_SEL-1:0]      idx;
    logic [HOLD_W_DEF-1:0] hold;
  } req_t;

  // Index to one-hot line; the index range always covers N_OUT exactly.
  function automatic logic [N_OUT-1:0] onehot(input logic [N_SEL-1:0] index);
    onehot = N_OUT'(1) << index;
  endfunction

endpackage

// File: rtl/priority_hold_counter.sv
// Down-counter that times how long the decoder drives a line.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : load load_val this cycle (takes priority over dec)
//   load_val    : value to load (cycles remaining minus one)
//   dec         : decrement by one; saturates at zero
//   is_zero_c   : combinational flag, counter currently holds zero
module priority_hold_counter #(
  parameter int unsigned HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  input  logic              dec,
  output logic              is_zero_c
);

  logic [HOLD_W-1:0] count_q;

  // Count register; never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - HOLD_W'(1);
    end
  end

  assign is_zero_c = (count_q == '0);

endmodule

// File: rtl/priority_decoder.sv
// Priority decoder: turns an encoded line index (plus the encoder's ZERO
// flag) back into a one-hot line driven for a programmable number of cycles,
// followed by a one-cycle completion pulse. One request in flight at a time.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   valid      : request present this cycle
//   ready      : block accepts a request this cycle (registered)
//   in         : encoded line index, captured on accept
//   zero       : no line selected, captured on accept
//   hold       : drive length in cycles, 0 behaves as 1, captured on accept
//   out        : registered one-hot line, or all zero
//   active     : high while out is being driven
//   done       : one-cycle completion pulse
module priority_decoder
  import priority_pkg::*;
#(
  parameter int unsigned HOLD_W = HOLD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  output logic              ready,
  input  logic [N_SEL-1:0]  in,
  input  logic              zero,
  input  logic [HOLD_W-1:0] hold,
  output logic [N_OUT-1:0]  out,
  output logic              active,
  output logic              done
);

  logic [ST_W-1:0]   state_q, state_d;
  logic [N_OUT-1:0]  out_q, out_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              accept_c;
  logic              cnt_load_c, cnt_dec_c, cnt_zero_c;
  logic [HOLD_W-1:0] cnt_init_c;

  // ready is only ever high in IDLE, so this is the accept condition.
  assign accept_c = valid && ready_q;

  // A hold of H drives for max(H,1) cycles; counter holds cycles left minus one.
  assign cnt_init_c = (hold == '0) ? '0 : hold - HOLD_W'(1);

  priority_hold_counter #(
    .HOLD_W (HOLD_W)
  ) u_hold_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cnt_load_c),
    .load_val  (cnt_init_c),
    .dec       (cnt_dec_c),
    .is_zero_c (cnt_zero_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      out_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      active_q <= active_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  // Next state and next-cycle output values.
  always_comb begin
    state_d    = state_q;
    out_d      = '0;
    active_d   = 1'b0;
    done_d     = 1'b0;
    ready_d    = 1'b0;
    cnt_load_c = 1'b0;
    cnt_dec_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (accept_c) begin
          ready_d = 1'b0;
          if (zero) begin
            // Encoder saw no request: skip straight to completion.
            state_d = ST_GAP;
            done_d  = 1'b1;
          end else begin
            state_d    = ST_DRIVE;
            out_d      = onehot(in);
            active_d   = 1'b1;
            cnt_load_c = 1'b1;
          end
        end
      end

      ST_DRIVE: begin
        if (cnt_zero_c) begin
          state_d = ST_GAP;
          done_d  = 1'b1;
        end else begin
          // out_q already holds the captured line.
          out_d     = out_q;
          active_d  = 1'b1;
          cnt_dec_c = 1'b1;
        end
      end

      ST_GAP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign out    = out_q;
  assign active = active_q;
  assign done   = done_q;
  assign ready  = ready_q;

endmodule
